// File: rtl/dict_writer.sv
// dict_writer: appends one dictionary entry (3-byte link to the previous entry,
// name bytes, 0x00 terminator) into a byte-wide SRAM and tracks here/latest.
module dict_writer #(
    parameter int DSZ  = 8,
    parameter int ASZ  = 17,
    parameter int NMAX = 31
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           s_vld,
    input  logic [DSZ-1:0] s_dat,
    input  logic           s_lst,
    output logic           s_rdy,
    output logic           mem_we,
    output logic [ASZ-1:0] mem_a,
    output logic [DSZ-1:0] mem_d,
    output logic [ASZ-1:0] here,
    output logic [ASZ-1:0] latest,
    output logic           bsy,
    output logic           done,
    output logic           err
);

    localparam int CW = $clog2(NMAX + 2);
    // Highest base address that still fits a maximum-length entry without wrapping.
    localparam logic [ASZ:0] LIMIT = (ASZ + 1)'((1 << ASZ) - (NMAX + 4));

    typedef enum logic [2:0] {
        IDLE,
        LNK0,
        LNK1,
        LNK2,
        NAME,
        TERM,
        DONE,
        ERR
    } state_t;

    state_t         state;
    logic [ASZ-1:0] e_base;
    logic [ASZ-1:0] wp;
    logic [CW-1:0]  cnt;
    logic           hs;
    logic           bad_byte;
    logic [23:0]    link_w;

    assign hs       = (state == NAME) && s_vld;
    assign bad_byte = hs && ((s_dat == '0) || (cnt == CW'(NMAX)));
    assign link_w   = 24'(latest);

    always_comb begin
        s_rdy  = (state == NAME);
        mem_we = 1'b0;
        mem_a  = wp;
        mem_d  = '0;
        case (state)
            LNK0: begin
                mem_we = 1'b1;
                mem_d  = DSZ'(link_w[7:0]);
            end
            LNK1: begin
                mem_we = 1'b1;
                mem_d  = DSZ'(link_w[15:8]);
            end
            LNK2: begin
                mem_we = 1'b1;
                mem_d  = DSZ'(link_w[23:16]);
            end
            NAME: begin
                mem_we = hs && !bad_byte;
                mem_d  = s_dat;
            end
            TERM: begin
                mem_we = 1'b1;
                mem_d  = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            here   <= '0;
            latest <= '0;
            e_base <= '0;
            wp     <= '0;
            cnt    <= '0;
            bsy    <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bsy    <= 1'b1;
                        e_base <= here;
                        wp     <= here;
                        cnt    <= '0;
                        if ({1'b0, here} <= LIMIT) begin
                            state <= LNK0;
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                LNK0: begin
                    wp    <= wp + 1'b1;
                    state <= LNK1;
                end
                LNK1: begin
                    wp    <= wp + 1'b1;
                    state <= LNK2;
                end
                LNK2: begin
                    wp    <= wp + 1'b1;
                    state <= NAME;
                end
                NAME: begin
                    if (hs) begin
                        if (bad_byte) begin
                            state <= ERR;
                            err   <= 1'b1;
                        end else begin
                            wp  <= wp + 1'b1;
                            cnt <= cnt + CW'(1);
                            if (s_lst) state <= TERM;
                        end
                    end
                end
                TERM: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    latest <= e_base;
                    here   <= wp + 1'b1;
                    bsy    <= 1'b0;
                    state  <= IDLE;
                end
                ERR: begin
                    bsy   <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dict_writer.sv
// Scoreboard bench for dict_writer: a default instance for the functional
// tests and a narrow-address instance for the no-wrap limit.
module tb_dict_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        s_vld = 1'b0;
    logic        s_lst = 1'b0;
    logic [7:0]  s_dat = 8'h00;
    logic        sel = 1'b0;
    logic        start_a, start_b;

    logic        a_rdy, a_we, a_bsy, a_done, a_err;
    logic [16:0] a_a, a_here, a_latest;
    logic [7:0]  a_d;
    logic        b_rdy, b_we, b_bsy, b_done, b_err;
    logic [8:0]  b_a, b_here, b_latest;
    logic [7:0]  b_d;

    logic        o_rdy, o_we, o_bsy, o_done, o_err;
    logic [16:0] o_a, o_here, o_latest;
    logic [7:0]  o_d;

    assign start_a = start & ~sel;
    assign start_b = start & sel;

    dict_writer u_a (
        .clk(clk), .rst(rst), .start(start_a), .s_vld(s_vld), .s_dat(s_dat), .s_lst(s_lst),
        .s_rdy(a_rdy), .mem_we(a_we), .mem_a(a_a), .mem_d(a_d), .here(a_here),
        .latest(a_latest), .bsy(a_bsy), .done(a_done), .err(a_err)
    );

    dict_writer #(.DSZ(8), .ASZ(9), .NMAX(31)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .s_vld(s_vld), .s_dat(s_dat), .s_lst(s_lst),
        .s_rdy(b_rdy), .mem_we(b_we), .mem_a(b_a), .mem_d(b_d), .here(b_here),
        .latest(b_latest), .bsy(b_bsy), .done(b_done), .err(b_err)
    );

    assign o_rdy    = sel ? b_rdy : a_rdy;
    assign o_we     = sel ? b_we : a_we;
    assign o_a      = sel ? 17'(b_a) : a_a;
    assign o_d      = sel ? b_d : a_d;
    assign o_here   = sel ? 17'(b_here) : a_here;
    assign o_latest = sel ? 17'(b_latest) : a_latest;
    assign o_bsy    = sel ? b_bsy : a_bsy;
    assign o_done   = sel ? b_done : a_done;
    assign o_err    = sel ? b_err : a_err;

    always #5 clk = ~clk;

    typedef struct packed {
        logic [16:0] a;
        logic [7:0]  d;
    } wr_t;

    int          total = 0;
    int          bad = 0;
    wr_t         exp_q[$];
    logic [16:0] m_here = '0;
    logic [16:0] m_latest = '0;
    logic [7:0]  nb[0:39];

    // Every write of the selected instance must match the next expected write.
    always @(negedge clk) begin : mon
        wr_t e;
        if (o_we === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write addr=%0d data=%02h (none expected)", o_a, o_d);
            end else begin
                e = exp_q.pop_front();
                if (o_a !== e.a || o_d !== e.d) begin
                    bad++;
                    $display("FAIL write got addr=%0d data=%02h exp addr=%0d data=%02h", o_a, o_d, e.a, e.d);
                end
            end
        end
        if ((sel ? a_we : b_we) !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL idle_instance_write got=%b exp=0", sel ? a_we : b_we);
        end
    end

    task automatic push_wr(input logic [16:0] a, input logic [7:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_q.push_back(w);
    endtask

    task automatic push_link();
        logic [23:0] l;
        l = 24'(m_latest);
        push_wr(m_here, l[7:0]);
        push_wr(m_here + 17'd1, l[15:8]);
        push_wr(m_here + 17'd2, l[23:16]);
    endtask

    task automatic check_q_empty(input string tag);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s pending_writes got=%0d exp=0", tag, exp_q.size());
        end
        exp_q.delete();
    endtask

    // Drives n bytes from nb[]; stall inserts two s_vld=0 cycles (with bait data) between bytes.
    task automatic stream(input int n, input bit lst_last, input bit stall, output bit ok);
        int  i;
        int  guard;
        bit  hs;
        i = 0;
        guard = 0;
        ok = 1'b1;
        while (i < n) begin
            s_vld = 1'b1;
            s_dat = nb[i];
            s_lst = lst_last && (i == n - 1);
            @(negedge clk);
            hs = (o_rdy === 1'b1);
            @(posedge clk);
            #1;
            if (hs) begin
                i++;
                if (stall && i < n) begin
                    s_vld = 1'b0;
                    s_dat = 8'h00;
                    s_lst = 1'b1;
                    repeat (2) @(posedge clk);
                    #1;
                end
            end
            guard++;
            if (guard > 200) begin
                ok = 1'b0;
                break;
            end
        end
        s_vld = 1'b0;
        s_lst = 1'b0;
        s_dat = 8'h00;
    endtask

    task automatic do_append(input int len, input bit stall, input string tag);
        bit          ok;
        logic [16:0] e;
        e = m_here;
        push_link();
        for (int i = 0; i < len; i++) push_wr(e + 17'd3 + 17'(i), nb[i]);
        push_wr(e + 17'd3 + 17'(len), 8'h00);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        stream(len, 1'b1, stall, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL %s stream_timeout got=stuck exp=accepted", tag); end
        @(negedge clk);
        total++;
        if (o_done !== 1'b0 || o_bsy !== 1'b1) begin
            bad++;
            $display("FAIL %s term_cycle got done=%b bsy=%b exp done=0 bsy=1", tag, o_done, o_bsy);
        end
        @(negedge clk);
        total++;
        if (o_done !== 1'b1 || o_err !== 1'b0 || o_bsy !== 1'b1) begin
            bad++;
            $display("FAIL %s done_pulse got done=%b err=%b bsy=%b exp 1 0 1", tag, o_done, o_err, o_bsy);
        end
        m_latest = e;
        m_here = e + 17'(len + 4);
        @(negedge clk);
        total++;
        if (o_done !== 1'b0 || o_bsy !== 1'b0 || o_here !== m_here || o_latest !== m_latest) begin
            bad++;
            $display("FAIL %s after_done got done=%b bsy=%b here=%0d latest=%0d exp 0 0 %0d %0d",
                     tag, o_done, o_bsy, o_here, o_latest, m_here, m_latest);
        end
        check_q_empty(tag);
        @(posedge clk);
        #1;
    endtask

    // Append that must abort in NAME: n bytes driven, only the first nwr written.
    task automatic do_err_append(input int n, input bit lst_last, input int nwr, input string tag);
        bit ok;
        push_link();
        for (int i = 0; i < nwr; i++) push_wr(m_here + 17'd3 + 17'(i), nb[i]);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        stream(n, lst_last, 1'b0, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL %s stream_timeout got=stuck exp=accepted", tag); end
        @(negedge clk);
        total++;
        if (o_err !== 1'b1 || o_done !== 1'b0 || o_bsy !== 1'b1 || o_rdy !== 1'b0) begin
            bad++;
            $display("FAIL %s err_pulse got err=%b done=%b bsy=%b rdy=%b exp 1 0 1 0",
                     tag, o_err, o_done, o_bsy, o_rdy);
        end
        @(negedge clk);
        total++;
        if (o_err !== 1'b0 || o_bsy !== 1'b0 || o_here !== m_here || o_latest !== m_latest) begin
            bad++;
            $display("FAIL %s after_err got err=%b bsy=%b here=%0d latest=%0d exp 0 0 %0d %0d",
                     tag, o_err, o_bsy, o_here, o_latest, m_here, m_latest);
        end
        check_q_empty(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        total++;
        if (o_here !== '0 || o_latest !== '0 || o_bsy !== 1'b0 || o_done !== 1'b0 ||
            o_err !== 1'b0 || o_rdy !== 1'b0 || o_we !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got here=%0d latest=%0d bsy=%b done=%b err=%b rdy=%b we=%b exp all 0",
                     o_here, o_latest, o_bsy, o_done, o_err, o_rdy, o_we);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_dup();
        nb[0] = 8'h44; nb[1] = 8'h55; nb[2] = 8'h50;
        do_append(3, 1'b0, "dup");
    endtask

    task automatic test_ok();
        nb[0] = 8'h4F; nb[1] = 8'h4B;
        do_append(2, 1'b0, "ok");
    endtask

    task automatic test_stall();
        nb[0] = 8'h58; nb[1] = 8'h59; nb[2] = 8'h5A;
        do_append(3, 1'b1, "stall");
    endtask

    task automatic test_too_long();
        for (int i = 0; i < 32; i++) nb[i] = 8'h61 + 8'(i % 26);
        do_err_append(32, 1'b0, 31, "too_long");
    endtask

    task automatic test_zero_byte();
        nb[0] = 8'h41; nb[1] = 8'h00;
        do_err_append(2, 1'b0, 1, "zero_byte");
    endtask

    task automatic test_mid_reset();
        bit ok;
        nb[0] = 8'h51; nb[1] = 8'h52; nb[2] = 8'h53;
        push_link();
        push_wr(m_here + 17'd3, nb[0]);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        stream(1, 1'b0, 1'b0, ok);
        s_vld = 1'b1;
        s_dat = nb[1];
        #1;
        rst = 1'b0;
        #1;
        total++;
        if (o_here !== '0 || o_latest !== '0 || o_bsy !== 1'b0 || o_done !== 1'b0 ||
            o_err !== 1'b0 || o_rdy !== 1'b0 || o_we !== 1'b0 || !ok) begin
            bad++;
            $display("FAIL mid_reset got here=%0d latest=%0d bsy=%b done=%b err=%b rdy=%b we=%b ok=%b exp all 0 ok=1",
                     o_here, o_latest, o_bsy, o_done, o_err, o_rdy, o_we, ok);
        end
        check_q_empty("mid_reset");
        s_vld = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_here = '0;
        m_latest = '0;
        // Start is raised in the same step as reset release.
        do_append(3, 1'b0, "after_reset");
    endtask

    task automatic test_limit();
        sel = 1'b1;
        m_here = '0;
        m_latest = '0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) nb[i] = 8'h41 + 8'(i % 26);
        for (int k = 0; k < 13; k++) do_append(31, 1'b0, "fill");
        do_append(18, 1'b0, "fill_last");
        total++;
        if (o_here !== 17'd477) begin
            bad++;
            $display("FAIL limit_fill got here=%0d exp=477", o_here);
        end
        do_append(1, 1'b0, "at_limit");
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        total++;
        if (o_err !== 1'b1 || o_rdy !== 1'b0) begin
            bad++;
            $display("FAIL over_limit_err got err=%b rdy=%b exp err=1 rdy=0", o_err, o_rdy);
        end
        @(negedge clk);
        total++;
        if (o_err !== 1'b0 || o_bsy !== 1'b0 || o_here !== m_here || o_latest !== m_latest) begin
            bad++;
            $display("FAIL over_limit_after got err=%b bsy=%b here=%0d latest=%0d exp 0 0 %0d %0d",
                     o_err, o_bsy, o_here, o_latest, m_here, m_latest);
        end
        check_q_empty("over_limit");
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_dup();
        test_ok();
        test_stall();
        test_too_long();
        test_zero_byte();
        test_mid_reset();
        test_limit();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dict_writer.md
DICT_WRITER -- requirements
Module: dict_writer

Interface
REQ-001 Parameter DSZ, default 8, memory data width in bits.
REQ-002 Parameter ASZ, default 17, memory address width in bits.
REQ-003 Parameter NMAX, default 31, maximum name length in bytes.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle request to append a new dictionary entry.
REQ-007 s_vld  input  1  name byte valid.
REQ-008 s_dat  input  DSZ  name byte.
REQ-009 s_lst  input  1  marks the final name byte.
REQ-010 s_rdy  output  1  name byte accepted when s_vld and s_rdy are both high.
REQ-011 mem_we  output  1  write enable to the 128K x 8 single-port SRAM.
REQ-012 mem_a  output  ASZ  write address.
REQ-013 mem_d  output  DSZ  write data.
REQ-014 here  output  ASZ  next free dictionary address.
REQ-015 latest  output  ASZ  start address of the most recently completed entry.
REQ-016 bsy  output  1  1 from the cycle after an accepted start until the cycle after DONE or ERR.
REQ-017 done  output  1  one-cycle pulse on successful append.
REQ-018 err  output  1  one-cycle pulse on aborted append.

Function
REQ-019 Entry layout at address E = here at start: E..E+2 link = latest, little-endian, bits above ASZ-1 zero; E+3.. name bytes; then one 0x00 terminator.
REQ-020 States: IDLE, LNK0, LNK1, LNK2, NAME, TERM, DONE, ERR.
REQ-021 IDLE: start=1 -> LNK0 when here <= 2^ASZ-(NMAX+4), else -> ERR; start ignored outside IDLE.
REQ-022 On accepted start the entry base E and write pointer wp = here are captured; here and latest do not change before DONE.
REQ-023 LNK0/LNK1/LNK2: one cycle each, mem_we=1, mem_a=E/E+1/E+2, mem_d=latest[7:0]/[15:8]/{zeros, latest[16]}; LNK2 -> NAME with wp=E+3.
REQ-024 NAME: s_rdy=1; on handshake, mem_we=1, mem_a=wp, mem_d=s_dat, wp increments that cycle; no handshake -> mem_we=0, stay in NAME.
REQ-025 NAME: handshake with s_lst=1 -> TERM.
REQ-026 NAME: handshake with s_dat=0x00, or the (NMAX+1)th byte, -> ERR with no write.
REQ-027 TERM: mem_we=1, mem_a=wp, mem_d=0x00 -> DONE.
REQ-028 DONE: done=1, latest<=E, here<=wp+1 (terminator address plus one) -> IDLE.
REQ-029 ERR: err=1, here and latest unchanged (bytes already written are abandoned) -> IDLE.
REQ-030 s_rdy=0 and mem_we=0 in IDLE, DONE, ERR; s_rdy=0 in LNKx and TERM.
REQ-031 mem_we, mem_a, mem_d, s_rdy are combinational decodes of state, wp and handshake; all other outputs are registered.
REQ-032 Name length 1..NMAX; entry size = length + 4 bytes; address arithmetic is ASZ bits, and the REQ-021 check guarantees no wrap.

Reset
REQ-033 rst=0 forces immediately: state IDLE, here=0, latest=0, wp=0, bsy=0, done=0, err=0, s_rdy=0, mem_we=0.
REQ-034 Reset mid-append aborts without done/err pulse; memory contents are not cleared.
REQ-035 First cycle after rst release accepts start.

Verification
REQ-036 Reset, start, stream "DUP" (0x44,0x55,0x50, lst on 0x50) -> writes 00,00,00,44,55,50,00 at 0..6; done pulse; here=7, latest=0.
REQ-037 Second append "OK" after REQ-036 -> writes 00,00,00,4F,4B,00 at 7..12; here=13, latest=7.
REQ-038 s_vld toggled 1,0,0,1 mid-name -> only valid cycles write; addresses contiguous; result identical to unstalled case.
REQ-039 Stream of 32 bytes without lst -> err pulse after 32nd handshake, no write of 32nd byte, here/latest unchanged.
REQ-040 here forced by prior appends to 2^17-34, start -> immediate ERR, no mem_we; byte 0x00 in name -> ERR.
REQ-041 rst=0 asserted during NAME -> all outputs at reset values same cycle; next append starts at address 0.
